dual_port_mem: RTL and testbench
================================

# dual_port_mem

Parametrised, byte-addressed, big-endian main memory with two independent channels: a read-only instruction port (I) and a read/write data port (D). It serves the fetch and memory stages of the pipelined processor. Every request gets a registered response after a fixed, parametrised latency. Each channel flags out-of-range and misaligned accesses, and sub-word loads are sign- or zero-extended.

## Interface
- BASE_ADDR, 32'h8002_0000: first byte address mapped by the array.
- SIZE_BYTES, 32'h0010_0000: array size in bytes; must be a multiple of 4.
- LATENCY, 1: accept-to-response delay in cycles; legal range 1..4.
- clk  in  1  clock; every action occurs on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  1  instruction fetch request.
- i_addr  in  32  fetch byte address; word access only.
- i_resp_valid  out  1  fetch response valid.
- i_rdata  out  32  fetched word, big-endian.
- i_err  out  1  fetch fault; valid only when i_resp_valid is high.
- d_req_valid  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- d_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- d_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- d_resp_valid  out  1  data response valid; issued for both loads and stores.
- d_rdata  out  32  load result; 0 for stores and faults.
- d_err  out  1  data fault; valid only when d_resp_valid is high.

## Operation
- Request acceptance: no ready signal. A request is accepted on any rising edge where rst_n=1 and valid=1. Both ports can accept one request every cycle, concurrently.
- Byte order: offset = addr − BASE_ADDR. Byte k of an access is stored at offset+k. The MSB is at the lowest address (big-endian).
- Fault conditions, per port:
  - addr < BASE_ADDR;
  - offset + bytes > SIZE_BYTES;
  - half-word access at an odd address;
  - word access with addr[1:0] ≠ 0;
  - d_size = 11.
  - The I port always checks as a word access.
- Fault response: err=1 and rdata=0. The array is not modified. A fault never blocks later requests.
- Store: the bytes selected by d_size are written from d_wdata[8·bytes−1:0] on the accept edge. The response carries rdata=0 and err=0.
- Load, byte: result = byte value placed in rdata[7:0], extended into [31:8].
- Load, half: result = half value placed in rdata[15:0], extended into [31:16].
- Load, word: the full 32-bit word is returned; extension does not apply.
- Cross-port hazard: an I read and a D store to overlapping bytes on the same edge → I returns the pre-store data (read-before-write).
- Same-port ordering: a D store followed by a D load to the same bytes on a later edge → the load returns the stored data.
- Reset: the array contents are not cleared. In-flight responses are discarded.

## Timing
- Array read happens on the accept edge. The result then passes through a delay line of LATENCY−1 further register stages.
- A request accepted at edge N produces resp_valid=1 with its data during cycle N+LATENCY, i.e. after edge N+LATENCY−1. With LATENCY=1, the response is visible in the cycle right after acceptance.
- resp_valid is high for exactly one cycle per accepted request.
- Responses come back in request order. Throughput is one response per cycle per port.
- No response backpressure: the consumer must sample the response in its valid cycle.
- Reset values: i_resp_valid, d_resp_valid, i_err and d_err are 0, and i_rdata and d_rdata are 32'h0. These values are held in the cycle after any edge where rst_n=0.
- Reset mid-operation:
  - Every delay-line stage is cleared.
  - Stores accepted before the reset edge remain committed.
  - A request presented on the reset edge is ignored.
- When valid=0 at an edge, the corresponding delay-line slot carries valid=0, err=0 and data=0. Outputs read 0 whenever resp_valid=0.

## Structure
- Package mem_pkg holds:
  - access-size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - a function that returns the byte count for a given size;
  - a function that returns the fault flag for (addr, size, BASE_ADDR, SIZE_BYTES).
- Sub-module mem_resp_pipe: a parametrised delay line of {valid, err, data[31:0]} with depth LATENCY−1 (pass-through when LATENCY=1) and synchronous active-low clear. It is instantiated once per port.
- The top level contains the byte array, the fault checks, the store byte-lane logic and the load extension logic.

## Test plan
- Reset with LATENCY=3, then a D word store of 32'hDEADBEEF at 32'h8002_0000, then a D byte load at 32'h8002_0001 with d_unsigned=1 → d_rdata = 32'h0000_00AD, d_resp_valid exactly 3 cycles after the load accept, err=0.
- D half store of 32'h0000_8001 at 32'h8002_0010, then a signed half load at the same address → 32'hFFFF_8001; the same load with d_unsigned=1 → 32'h0000_8001.
- Same edge: I fetch at 32'h8002_0020 (holding 32'h1111_1111) and D store of 32'h2222_2222 to the same address → I returns 32'h1111_1111; a later fetch returns 32'h2222_2222.
- Faults, each with err=1, rdata=0 and no array change:
  - D word at 32'h8002_0002;
  - D half at 32'h8002_0003;
  - I fetch at 32'h8001_FFFC;
  - D word at 32'h8012_0000;
  - d_size=11.
- Back-to-back: 8 consecutive I fetches and 8 mixed D requests on both ports every cycle → 8 in-order responses per port on consecutive cycles, with no drops.
- Assert rst_n=0 for one edge while 2 responses are in flight (LATENCY=3) → no resp_valid afterwards. Outputs read 0, and the store accepted before reset reads back intact.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared access-size codes, response record and access-check helpers
// for the dual-port main memory.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // The end check is done in 33 bits so an offset near 2^32 cannot wrap into range.
    function automatic logic access_fault(
        input logic [31:0] addr,
        input logic [1:0]  size,
        input logic [31:0] base,
        input logic [31:0] span
    );
        logic [32:0] w_end;
        logic        w_fault;
        w_end   = {1'b0, addr - base} + {30'd0, access_bytes(size)};
        w_fault = (size == SZ_ILLEGAL) || (addr < base) || (w_end > {1'b0, span});
        if (size == SZ_HALF && addr[0]) begin
            w_fault = 1'b1;
        end
        if (size == SZ_WORD && addr[1:0] != 2'b00) begin
            w_fault = 1'b1;
        end
        return w_fault;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Delay line for {valid, err, data} responses; DEPTH of zero is a plain wire.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  resp_t i_resp,
    output resp_t o_resp
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_ctrl;
            assign w_unused_ctrl = clk ^ rst_n;
            assign o_resp        = i_resp;
        end else begin : g_stages
            resp_t r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_stage[k] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_resp;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            assign o_resp = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dual_port_mem.sv
// Big-endian byte-addressed main memory with a read-only fetch port and a
// read/write data port, each answering after a fixed LATENCY.
module dual_port_mem
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8002_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0010_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic [31:0] i_addr,
    output logic        i_resp_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req_valid,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    localparam int AW = $clog2(SIZE_BYTES);

    logic [7:0]    r_mem [SIZE_BYTES];

    logic          w_i_fault;
    logic          w_d_fault;
    logic [AW-1:0] w_i_base;
    logic [AW-1:0] w_d_base;
    logic [31:0]   w_i_word;
    logic [31:0]   w_d_word;
    logic [31:0]   w_d_load;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic          w_d_store_en;

    resp_t         r_i_stage;
    resp_t         r_d_stage;
    resp_t         w_i_out;
    resp_t         w_d_out;

    assign w_i_fault = access_fault(i_addr, SZ_WORD, BASE_ADDR, SIZE_BYTES);
    assign w_d_fault = access_fault(d_addr, d_size, BASE_ADDR, SIZE_BYTES);

    // Both ports read the whole aligned word; lane selection happens afterwards.
    assign w_i_base = AW'((i_addr - BASE_ADDR) & 32'hFFFF_FFFC);
    assign w_d_base = AW'((d_addr - BASE_ADDR) & 32'hFFFF_FFFC);

    always_comb begin
        w_i_word = '0;
        w_d_word = '0;
        for (int k = 0; k < 4; k++) begin
            w_i_word[31-8*k -: 8] = r_mem[w_i_base + AW'(k)];
            w_d_word[31-8*k -: 8] = r_mem[w_d_base + AW'(k)];
        end
    end

    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        w_d_load = w_d_word;
        case (d_addr[1:0])
            2'd0:    w_byte = w_d_word[31:24];
            2'd1:    w_byte = w_d_word[23:16];
            2'd2:    w_byte = w_d_word[15:8];
            default: w_byte = w_d_word[7:0];
        endcase
        w_half = d_addr[1] ? w_d_word[15:0] : w_d_word[31:16];
        case (d_size)
            SZ_BYTE: w_d_load = {{24{~d_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_d_load = {{16{~d_unsigned & w_half[15]}}, w_half};
            default: w_d_load = w_d_word;
        endcase
    end

    // w_be bit (3-k) enables lane k, where lane 0 is the lowest (most significant) byte.
    always_comb begin
        w_be = 4'b0000;
        w_wd = d_wdata;
        case (d_size)
            SZ_BYTE: begin
                w_be = 4'b1000 >> d_addr[1:0];
                w_wd = {4{d_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be = d_addr[1] ? 4'b0011 : 4'b1100;
                w_wd = {2{d_wdata[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_d_store_en = rst_n && d_req_valid && d_we && !w_d_fault;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_d_store_en && w_be[3-k]) begin
                r_mem[w_d_base + AW'(k)] <= w_wd[31-8*k -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_stage <= '0;
            r_d_stage <= '0;
        end else begin
            r_i_stage.valid <= i_req_valid;
            r_i_stage.err   <= i_req_valid && w_i_fault;
            r_i_stage.data  <= (i_req_valid && !w_i_fault) ? w_i_word : 32'h0;
            r_d_stage.valid <= d_req_valid;
            r_d_stage.err   <= d_req_valid && w_d_fault;
            r_d_stage.data  <= (d_req_valid && !w_d_fault && !d_we) ? w_d_load : 32'h0;
        end
    end

    mem_resp_pipe #(.DEPTH(LATENCY - 1)) u_i_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_resp (r_i_stage),
        .o_resp (w_i_out)
    );

    mem_resp_pipe #(.DEPTH(LATENCY - 1)) u_d_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_resp (r_d_stage),
        .o_resp (w_d_out)
    );

    assign i_resp_valid = w_i_out.valid;
    assign i_err        = w_i_out.err;
    assign i_rdata      = w_i_out.data;
    assign d_resp_valid = w_d_out.valid;
    assign d_err        = w_d_out.err;
    assign d_rdata      = w_d_out.data;

endmodule

// File: tb/tb_dual_port_mem.sv
// Directed self-checking bench for dual_port_mem at LATENCY=3.
module tb_dual_port_mem;
    import mem_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        iReqValid = 1'b0;
    logic [31:0] iAddr = '0;
    logic        iRespValid;
    logic [31:0] iRdata;
    logic        iErr;
    logic        dReqValid = 1'b0;
    logic        dWe = 1'b0;
    logic [31:0] dAddr = '0;
    logic [1:0]  dSize = SZ_WORD;
    logic        dUnsigned = 1'b0;
    logic [31:0] dWdata = '0;
    logic        dRespValid;
    logic [31:0] dRdata;
    logic        dErr;

    int          assertCount = 0;
    int          failCount = 0;

    logic [31:0] gotI;
    logic        gotIErr;
    logic [31:0] gotD;
    logic        gotDErr;
    int          gotLat;

    always #5 clk = ~clk;

    dual_port_mem #(
        .BASE_ADDR  (32'h8002_0000),
        .SIZE_BYTES (32'h0010_0000),
        .LATENCY    (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .i_req_valid  (iReqValid),
        .i_addr       (iAddr),
        .i_resp_valid (iRespValid),
        .i_rdata      (iRdata),
        .i_err        (iErr),
        .d_req_valid  (dReqValid),
        .d_we         (dWe),
        .d_addr       (dAddr),
        .d_size       (dSize),
        .d_unsigned   (dUnsigned),
        .d_wdata      (dWdata),
        .d_resp_valid (dRespValid),
        .d_rdata      (dRdata),
        .d_err        (dErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on either or both ports and wait (bounded) for the response.
    task automatic txn(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic we, input logic [31:0] da,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        iReqValid = iv;
        iAddr     = ia;
        dReqValid = dv;
        dWe       = we;
        dAddr     = da;
        dSize     = sz;
        dUnsigned = uns;
        dWdata    = wd;
        tick();
        iReqValid = 1'b0;
        dReqValid = 1'b0;
        dWe       = 1'b0;
        gotLat    = 1;
        while (!((iv && iRespValid) || (dv && dRespValid)) && gotLat < 10) begin
            tick();
            gotLat++;
        end
        gotI    = iRdata;
        gotIErr = iErr;
        gotD    = dRdata;
        gotDErr = dErr;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick();
        tick();
        assertCount++;
        if ({iRespValid, iErr, iRdata, dRespValid, dErr, dRdata} !== 66'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {iRespValid, iErr, iRdata, dRespValid, dErr, dRdata});
        end
        rstN = 1'b1;
        tick();
        assertCount++;
        if ({iRespValid, iErr, iRdata, dRespValid, dErr, dRdata} !== 66'd0) begin
            failCount++;
            $display("[TB] FAIL idle_after_reset: got %h expected 0",
                     {iRespValid, iErr, iRdata, dRespValid, dErr, dRdata});
        end
    endtask

    task automatic test_word_byte();
        txn(0, '0, 1, 1, 32'h8002_0000, SZ_WORD, 0, 32'hDEAD_BEEF);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL store_word_resp: got %h expected %h", {gotDErr, gotD}, {1'b0, 32'h0});
        end
        txn(0, '0, 1, 0, 32'h8002_0001, SZ_BYTE, 1, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'h0000_00AD}) begin
            failCount++;
            $display("[TB] FAIL load_byte_u: got %h expected %h", {gotDErr, gotD}, {1'b0, 32'h0000_00AD});
        end
        assertCount++;
        if (gotLat !== LAT) begin
            failCount++;
            $display("[TB] FAIL load_latency: got %0d expected %0d", gotLat, LAT);
        end
        tick();
        assertCount++;
        if ({dRespValid, dRdata} !== 33'd0) begin
            failCount++;
            $display("[TB] FAIL single_cycle_valid: got %h expected 0", {dRespValid, dRdata});
        end
        txn(0, '0, 1, 0, 32'h8002_0003, SZ_BYTE, 0, 32'h0);
        assertCount++;
        if (gotD !== 32'hFFFF_FFEF) begin
            failCount++;
            $display("[TB] FAIL load_byte_s: got %h expected %h", gotD, 32'hFFFF_FFEF);
        end
        txn(0, '0, 1, 1, 32'h8002_0014, SZ_WORD, 0, 32'hA1B2_C3D4);
        txn(0, '0, 1, 1, 32'h8002_0015, SZ_BYTE, 0, 32'hFFFF_FF5A);
        txn(0, '0, 1, 0, 32'h8002_0014, SZ_WORD, 0, 32'h0);
        assertCount++;
        if (gotD !== 32'hA15A_C3D4) begin
            failCount++;
            $display("[TB] FAIL byte_lane_store: got %h expected %h", gotD, 32'hA15A_C3D4);
        end
    endtask

    task automatic test_half();
        txn(0, '0, 1, 1, 32'h8002_0010, SZ_HALF, 0, 32'h0000_8001);
        txn(0, '0, 1, 0, 32'h8002_0010, SZ_HALF, 0, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'hFFFF_8001}) begin
            failCount++;
            $display("[TB] FAIL load_half_s: got %h expected %h", {gotDErr, gotD}, {1'b0, 32'hFFFF_8001});
        end
        txn(0, '0, 1, 0, 32'h8002_0010, SZ_HALF, 1, 32'h0);
        assertCount++;
        if (gotD !== 32'h0000_8001) begin
            failCount++;
            $display("[TB] FAIL load_half_u: got %h expected %h", gotD, 32'h0000_8001);
        end
    endtask

    task automatic test_hazard();
        txn(0, '0, 1, 1, 32'h8002_0020, SZ_WORD, 0, 32'h1111_1111);
        txn(1, 32'h8002_0020, 1, 1, 32'h8002_0020, SZ_WORD, 0, 32'h2222_2222);
        assertCount++;
        if ({gotIErr, gotI} !== {1'b0, 32'h1111_1111}) begin
            failCount++;
            $display("[TB] FAIL read_before_write: got %h expected %h", {gotIErr, gotI}, {1'b0, 32'h1111_1111});
        end
        txn(1, 32'h8002_0020, 0, 0, '0, SZ_WORD, 0, '0);
        assertCount++;
        if (gotI !== 32'h2222_2222) begin
            failCount++;
            $display("[TB] FAIL fetch_after_store: got %h expected %h", gotI, 32'h2222_2222);
        end
    endtask

    task automatic test_faults();
        txn(0, '0, 1, 1, 32'h8002_0002, SZ_WORD, 0, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL word_misaligned: got %h expected %h", {gotDErr, gotD}, {1'b1, 32'h0});
        end
        txn(0, '0, 1, 1, 32'h8002_0003, SZ_HALF, 0, 32'h0000_FFFF);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL half_misaligned: got %h expected %h", {gotDErr, gotD}, {1'b1, 32'h0});
        end
        txn(1, 32'h8001_FFFC, 0, 0, '0, SZ_WORD, 0, '0);
        assertCount++;
        if ({gotIErr, gotI} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL fetch_below_base: got %h expected %h", {gotIErr, gotI}, {1'b1, 32'h0});
        end
        txn(0, '0, 1, 0, 32'h8012_0000, SZ_WORD, 0, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL word_past_end: got %h expected %h", {gotDErr, gotD}, {1'b1, 32'h0});
        end
        txn(0, '0, 1, 1, 32'h8002_0000, SZ_ILLEGAL, 0, 32'hFFFF_FFFF);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL illegal_size: got %h expected %h", {gotDErr, gotD}, {1'b1, 32'h0});
        end
        txn(0, '0, 1, 0, 32'h8002_0000, SZ_WORD, 0, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'hDEAD_BEEF}) begin
            failCount++;
            $display("[TB] FAIL fault_no_write: got %h expected %h", {gotDErr, gotD}, {1'b0, 32'hDEAD_BEEF});
        end
        txn(0, '0, 1, 1, 32'h8011_FFFC, SZ_WORD, 0, 32'h0CAF_EF00);
        txn(0, '0, 1, 0, 32'h8011_FFFC, SZ_WORD, 0, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'h0CAF_EF00}) begin
            failCount++;
            $display("[TB] FAIL last_word: got %h expected %h", {gotDErr, gotD}, {1'b0, 32'h0CAF_EF00});
        end
        txn(0, '0, 1, 0, 32'h8011_FFFF, SZ_BYTE, 1, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL last_byte: got %h expected %h", {gotDErr, gotD}, {1'b0, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] iRes [16];
        logic [32:0] dRes [16];
        int          iCyc [16];
        int          dCyc [16];
        int          iCount;
        int          dCount;
        logic [31:0] expD;
        iCount = 0;
        dCount = 0;
        for (int i = 0; i < 8; i++) begin
            txn(0, '0, 1, 1, 32'h8002_0040 + 32'(4 * i), SZ_WORD, 0, 32'hC0DE_0000 + 32'(i));
        end
        txn(0, '0, 1, 1, 32'h8002_0060, SZ_WORD, 0, 32'h0);
        txn(0, '0, 1, 1, 32'h8002_0064, SZ_WORD, 0, 32'h0);
        for (int c = 0; c < 8 + LAT + 2; c++) begin
            iReqValid = (c < 8);
            dReqValid = (c < 8);
            iAddr     = 32'h8002_0040 + 32'(4 * c);
            dUnsigned = 1'b0;
            if (c % 2 == 0) begin
                dWe   = 1'b0;
                dAddr = 32'h8002_0040 + 32'(4 * c);
                dSize = SZ_WORD;
            end else begin
                dWe    = 1'b1;
                dAddr  = 32'h8002_0060 + 32'(c);
                dSize  = SZ_BYTE;
                dWdata = 32'h0000_00A0 + 32'(c);
            end
            tick();
            if (iRespValid && iCount < 16) begin
                iRes[iCount] = iRdata;
                iCyc[iCount] = c;
                iCount++;
            end
            if (dRespValid && dCount < 16) begin
                dRes[dCount] = {dErr, dRdata};
                dCyc[dCount] = c;
                dCount++;
            end
        end
        iReqValid = 1'b0;
        dReqValid = 1'b0;
        dWe       = 1'b0;
        assertCount++;
        if (iCount !== 8 || dCount !== 8) begin
            failCount++;
            $display("[TB] FAIL b2b_counts: got i=%0d d=%0d expected 8 each", iCount, dCount);
        end
        assertCount++;
        if (iCyc[0] !== LAT - 1) begin
            failCount++;
            $display("[TB] FAIL b2b_first_cycle: got %0d expected %0d", iCyc[0], LAT - 1);
        end
        for (int k = 0; k < 8 && k < iCount && k < dCount; k++) begin
            expD = (k % 2 == 0) ? 32'hC0DE_0000 + 32'(k) : 32'h0;
            assertCount++;
            if (iRes[k] !== 32'hC0DE_0000 + 32'(k) || iCyc[k] !== iCyc[0] + k) begin
                failCount++;
                $display("[TB] FAIL b2b_i%0d: got %h @%0d expected %h @%0d",
                         k, iRes[k], iCyc[k], 32'hC0DE_0000 + 32'(k), iCyc[0] + k);
            end
            assertCount++;
            if (dRes[k] !== {1'b0, expD} || dCyc[k] !== dCyc[0] + k) begin
                failCount++;
                $display("[TB] FAIL b2b_d%0d: got %h @%0d expected %h @%0d",
                         k, dRes[k], dCyc[k], {1'b0, expD}, dCyc[0] + k);
            end
        end
        txn(0, '0, 1, 0, 32'h8002_0060, SZ_WORD, 0, 32'h0);
        assertCount++;
        if (gotD !== 32'h00A1_00A3) begin
            failCount++;
            $display("[TB] FAIL b2b_stores_lo: got %h expected %h", gotD, 32'h00A1_00A3);
        end
        txn(0, '0, 1, 0, 32'h8002_0064, SZ_WORD, 0, 32'h0);
        assertCount++;
        if (gotD !== 32'h00A5_00A7) begin
            failCount++;
            $display("[TB] FAIL b2b_stores_hi: got %h expected %h", gotD, 32'h00A5_00A7);
        end
    endtask

    task automatic test_reset_midflight();
        int leaks;
        leaks = 0;
        txn(0, '0, 1, 1, 32'h8002_0080, SZ_WORD, 0, 32'h5A5A_5A5A);
        for (int c = 0; c < 2; c++) begin
            iReqValid = 1'b1;
            iAddr     = 32'h8002_0080;
            dReqValid = 1'b1;
            dWe       = 1'b0;
            dAddr     = 32'h8002_0080;
            dSize     = SZ_WORD;
            tick();
        end
        rstN      = 1'b0;
        dWe       = 1'b1;
        dWdata    = 32'h0;
        tick();
        assertCount++;
        if ({iRespValid, iErr, iRdata, dRespValid, dErr, dRdata} !== 66'd0) begin
            failCount++;
            $display("[TB] FAIL midflight_reset_outputs: got %h expected 0",
                     {iRespValid, iErr, iRdata, dRespValid, dErr, dRdata});
        end
        rstN      = 1'b1;
        iReqValid = 1'b0;
        dReqValid = 1'b0;
        dWe       = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if ({iRespValid, iErr, iRdata, dRespValid, dErr, dRdata} !== 66'd0) begin
                leaks++;
            end
        end
        assertCount++;
        if (leaks !== 0) begin
            failCount++;
            $display("[TB] FAIL midflight_no_resp: got %0d active cycles expected 0", leaks);
        end
        txn(0, '0, 1, 0, 32'h8002_0080, SZ_WORD, 0, 32'h0);
        assertCount++;
        if ({gotDErr, gotD} !== {1'b0, 32'h5A5A_5A5A} || gotLat !== LAT) begin
            failCount++;
            $display("[TB] FAIL store_survives_reset: got %h lat %0d expected %h lat %0d",
                     {gotDErr, gotD}, gotLat, {1'b0, 32'h5A5A_5A5A}, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_half();
        test_hazard();
        test_faults();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
